// File: rtl/core_pkg.sv
// Shared definitions for the integer/float register files: default sizes,
// register-file flavour encodings and the write-port arbitration helper.
package core_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  // ZERO_REG encodings: integer file hardwires x0, float file does not.
  localparam int INT_RF = 1;
  localparam int FP_RF  = 0;

  // Upper bounds used by the arbitration helper. Callers zero-pad their
  // write-port vectors up to these sizes, so NUM_WR must not exceed MAX_WR
  // and ADDR_WIDTH must not exceed MAX_AW.
  localparam int MAX_WR   = 8;
  localparam int MAX_AW   = 8;
  localparam int WR_IDX_W = 3;

  // Result of write-port arbitration for one register address.
  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] port;
  } wr_sel_t;

  // Find the highest-index enabled write port that targets addr. Scanning
  // upwards and overwriting on every match leaves the highest port in sel.
  function automatic wr_sel_t win_port(
    input logic [MAX_WR-1:0]        en,
    input logic [MAX_WR*MAX_AW-1:0] addrs,
    input logic [MAX_AW-1:0]        addr
  );
    wr_sel_t sel;
    sel.hit  = 1'b0;
    sel.port = {WR_IDX_W{1'b0}};
    for (int j = 0; j < MAX_WR; j++) begin
      if (en[j] && (addrs[j*MAX_AW +: MAX_AW] == addr)) begin
        sel.hit  = 1'b1;
        sel.port = WR_IDX_W'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for issue-stage hazard detection. Reservations
// take priority over same-cycle write clears; the post-edge pending vector
// is exported so read ports can report it with one cycle of latency.
module rf_scoreboard
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = INT_RF
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [2**ADDR_WIDTH-1:0] wr_clr,
  input  logic                     rsv_en,
  input  logic [ADDR_WIDTH-1:0]    rsv_addr,
  output logic [2**ADDR_WIDTH-1:0] pend_next,
  output logic                     any_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_next_s;
  logic [DEPTH-1:0] rsv_hit_s;
  logic             any_busy_r;

  // Next pending state: reserve sets, a committed write clears, else hold.
  always_comb begin
    rsv_hit_s   = {DEPTH{1'b0}};
    pend_next_s = {DEPTH{1'b0}};
    for (int a = 0; a < DEPTH; a++) begin
      rsv_hit_s[a] = rsv_en && (rsv_addr == ADDR_WIDTH'(a)) &&
                     !((ZERO_REG != 0) && (a == 0));
      pend_next_s[a] = rsv_hit_s[a] ? 1'b1 :
                       (wr_clr[a]   ? 1'b0 : pend_r[a]);
    end
  end

  // Pending vector and its registered OR; clear wipes everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      pend_r     <= {DEPTH{1'b0}};
      any_busy_r <= 1'b0;
    end else begin
      pend_r     <= pend_next_s;
      any_busy_r <= |pend_next_s;
    end
  end

  assign pend_next = pend_next_s;
  assign any_busy  = any_busy_r;

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised multi-port register file shared by the integer and float
// pipelines: N read / M write ports, optional hardwired x0, same-cycle
// write-to-read bypass and a pending-bit scoreboard. All outputs are
// registered; reads return the post-edge state of the addressed register.
module multiport_regfile
  import core_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = INT_RF
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]      wr_data,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic                         any_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [WIDTH-1:0]         regs_r    [DEPTH];
  logic [MAX_WR-1:0]        wr_en_pad_s;
  logic [MAX_WR*MAX_AW-1:0] wr_addr_pad_s;
  logic [WIDTH-1:0]         wr_data_s [NUM_WR];
  wr_sel_t                  wr_sel_s  [DEPTH];
  logic [DEPTH-1:0]         wr_hit_s;
  logic [WIDTH-1:0]         wr_val_s  [DEPTH];
  logic [DEPTH-1:0]         pend_next_s;
  logic [ADDR_WIDTH-1:0]    rd_addr_s [NUM_RD];
  logic [WIDTH-1:0]         rd_data_r [NUM_RD];
  logic [NUM_RD-1:0]        rd_busy_r;

  // Unpack write ports and zero-pad them to the arbitration helper's size.
  always_comb begin
    wr_en_pad_s   = {MAX_WR{1'b0}};
    wr_addr_pad_s = {(MAX_WR*MAX_AW){1'b0}};
    for (int j = 0; j < NUM_WR; j++) begin
      wr_en_pad_s[j]                   = wr_en[j];
      wr_addr_pad_s[j*MAX_AW +: MAX_AW] = MAX_AW'(wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]);
      wr_data_s[j]                     = wr_data[j*WIDTH +: WIDTH];
    end
  end

  // Resolve the winning write per register; the same result feeds storage
  // and bypass so both always agree. Writes to a hardwired x0 never commit.
  always_comb begin
    wr_hit_s = {DEPTH{1'b0}};
    for (int a = 0; a < DEPTH; a++) begin
      wr_sel_s[a] = win_port(wr_en_pad_s, wr_addr_pad_s, MAX_AW'(a));
      wr_hit_s[a] = wr_sel_s[a].hit && !((ZERO_REG != 0) && (a == 0));
      wr_val_s[a] = {WIDTH{1'b0}};
      for (int j = 0; j < NUM_WR; j++) begin
        wr_val_s[a] = (wr_sel_s[a].port == WR_IDX_W'(j)) ? wr_data_s[j] : wr_val_s[a];
      end
    end
  end

  // Unpack read addresses.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr_s[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Register storage update.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int a = 0; a < DEPTH; a++) begin
        regs_r[a] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (wr_hit_s[a]) begin
          regs_r[a] <= wr_val_s[a];
        end
      end
    end
  end

  // Read ports: load post-edge data (bypassing same-cycle writes) and the
  // post-edge pending bit; a disabled port holds its last result.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_RD; i++) begin
        rd_data_r[i] <= {WIDTH{1'b0}};
      end
      rd_busy_r <= {NUM_RD{1'b0}};
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          if ((ZERO_REG != 0) && (rd_addr_s[i] == {ADDR_WIDTH{1'b0}})) begin
            rd_data_r[i] <= {WIDTH{1'b0}};
            rd_busy_r[i] <= 1'b0;
          end else begin
            rd_data_r[i] <= wr_hit_s[rd_addr_s[i]] ? wr_val_s[rd_addr_s[i]]
                                                   : regs_r[rd_addr_s[i]];
            rd_busy_r[i] <= pend_next_s[rd_addr_s[i]];
          end
        end
      end
    end
  end

  // Repack registered read data onto the output bus.
  always_comb begin
    rd_data = {(NUM_RD*WIDTH){1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*WIDTH +: WIDTH] = rd_data_r[i];
    end
  end

  assign rd_busy = rd_busy_r;

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clock     (clock),
    .clear     (clear),
    .wr_clr    (wr_hit_s),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .pend_next (pend_next_s),
    .any_busy  (any_busy)
  );

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench: an integer-flavour (x0 hardwired) and a float-flavour
// instance share all stimulus. Directed table, hand sequences and random
// traffic are all compared against a behavioural model.
module tb_multiport_regfile;
  import core_pkg::*;

  logic        clock;
  logic        clear;
  logic [2:0]  rd_en;
  logic [4:0]  ra [3];
  logic [1:0]  wr_en;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [14:0] rd_addr_v;
  logic [9:0]  wr_addr_v;
  logic [63:0] wr_data_v;
  assign rd_addr_v = {ra[2], ra[1], ra[0]};
  assign wr_addr_v = {wa[1], wa[0]};
  assign wr_data_v = {wd[1], wd[0]};

  logic [95:0] rd_data_i, rd_data_f;
  logic [2:0]  rd_busy_i, rd_busy_f;
  logic        any_i, any_f;

  multiport_regfile #(.WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(3), .NUM_WR(2), .ZERO_REG(INT_RF)) dut_int (
    .clock(clock), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr_v),
    .rd_data(rd_data_i), .rd_busy(rd_busy_i), .wr_en(wr_en), .wr_addr(wr_addr_v),
    .wr_data(wr_data_v), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(any_i));

  multiport_regfile #(.WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(3), .NUM_WR(2), .ZERO_REG(FP_RF)) dut_fp (
    .clock(clock), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr_v),
    .rd_data(rd_data_f), .rd_busy(rd_busy_f), .wr_en(wr_en), .wr_addr(wr_addr_v),
    .wr_data(wr_data_v), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(any_f));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model; index 0 = integer file, 1 = float file.
  logic [31:0] m_reg  [2][32];
  logic        m_pend [2][32];
  logic [31:0] m_rd   [2][3];
  logic        m_busy [2][3];
  logic        m_any  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 32; a++) begin
        m_reg[d][a]  = 32'h0;
        m_pend[d][a] = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        m_rd[d][i]   = 32'h0;
        m_busy[d][i] = 1'b0;
      end
      m_any[d] = 1'b0;
    end
  endtask

  // Apply one clock's worth of the specified rules in plain sequential order:
  // writes in ascending port order (so the higher port wins), then reserve,
  // then reads see the resulting state.
  task automatic model_step();
    bit z;
    for (int d = 0; d < 2; d++) begin
      z = (d == 0);
      if (clear) begin
        for (int a = 0; a < 32; a++) begin
          m_reg[d][a]  = 32'h0;
          m_pend[d][a] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
          m_rd[d][i]   = 32'h0;
          m_busy[d][i] = 1'b0;
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          if (wr_en[j] && !(z && wa[j] == 5'd0)) begin
            m_reg[d][wa[j]]  = wd[j];
            m_pend[d][wa[j]] = 1'b0;
          end
        end
        if (rsv_en && !(z && rsv_addr == 5'd0)) m_pend[d][rsv_addr] = 1'b1;
        for (int i = 0; i < 3; i++) begin
          if (rd_en[i]) begin
            if (z && ra[i] == 5'd0) begin
              m_rd[d][i]   = 32'h0;
              m_busy[d][i] = 1'b0;
            end else begin
              m_rd[d][i]   = m_reg[d][ra[i]];
              m_busy[d][i] = m_pend[d][ra[i]];
            end
          end
        end
      end
      m_any[d] = 1'b0;
      for (int a = 0; a < 32; a++) m_any[d] = m_any[d] | m_pend[d][a];
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("int_rd_data%0d", i), rd_data_i[i*32 +: 32], m_rd[0][i]);
      chk($sformatf("int_rd_busy%0d", i), {31'h0, rd_busy_i[i]}, {31'h0, m_busy[0][i]});
      chk($sformatf("fp_rd_data%0d", i),  rd_data_f[i*32 +: 32], m_rd[1][i]);
      chk($sformatf("fp_rd_busy%0d", i),  {31'h0, rd_busy_f[i]}, {31'h0, m_busy[1][i]});
    end
    chk("int_any_busy", {31'h0, any_i}, {31'h0, m_any[0]});
    chk("fp_any_busy",  {31'h0, any_f}, {31'h0, m_any[1]});
  endtask

  task automatic idle();
    clear = 1'b0; rd_en = 3'b000; wr_en = 2'b00; rsv_en = 1'b0; rsv_addr = 5'd0;
    for (int i = 0; i < 3; i++) ra[i] = 5'd0;
    for (int j = 0; j < 2; j++) begin wa[j] = 5'd0; wd[j] = 32'h0; end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic        clr;
    logic [1:0]  we;
    logic [4:0]  wa0;  logic [31:0] wd0;
    logic [4:0]  wa1;  logic [31:0] wd1;
    logic        re;   logic [4:0]  rsa;
    logic [4:0]  rda;
    logic [31:0] e_dat; logic e_busy; logic e_any;
    logic [31:0] e_fp;
  } vec_t;

  vec_t tbl [14];

  initial begin
    idle();
    model_reset();
    //              clr   we     wa0    wd0           wa1    wd1          re    rsa    rda    e_dat         busy  any   e_fp
    tbl[0]  = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       1'b0, 5'd0,  5'd7,  32'h22,       1'b0, 1'b0, 32'h22};
    tbl[4]  = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  32'h22,       1'b0, 1'b0, 32'h22};
    tbl[5]  = '{1'b0, 2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 32'hFFFFFFFF};
    tbl[6]  = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 32'hFFFFFFFF};
    tbl[7]  = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  32'h0,        1'b1, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  32'h0,        1'b1, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 2'b01, 5'd9,  32'h3,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  32'h3,        1'b0, 1'b0, 32'h3};
    tbl[10] = '{1'b0, 2'b10, 5'd0,  32'h0,        5'd9,  32'h4,        1'b1, 5'd9,  5'd9,  32'h4,        1'b1, 1'b1, 32'h4};
    tbl[11] = '{1'b1, 2'b01, 5'd3,  32'h55,       5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  32'h0,        1'b0, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  32'h0,        1'b0, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  32'h0,        1'b0, 1'b0, 32'h0};

    @(negedge clock);
    for (int k = 0; k < 14; k++) begin
      clear = tbl[k].clr; wr_en = tbl[k].we;
      wa[0] = tbl[k].wa0; wd[0] = tbl[k].wd0;
      wa[1] = tbl[k].wa1; wd[1] = tbl[k].wd1;
      rsv_en = tbl[k].re; rsv_addr = tbl[k].rsa;
      rd_en = 3'b111;
      for (int i = 0; i < 3; i++) ra[i] = tbl[k].rda;
      cycle();
      for (int i = 0; i < 3; i++)
        chk($sformatf("vec%0d_int_data%0d", k, i), rd_data_i[i*32 +: 32], tbl[k].e_dat);
      chk($sformatf("vec%0d_int_busy", k), {31'h0, rd_busy_i[0]}, {31'h0, tbl[k].e_busy});
      chk($sformatf("vec%0d_int_any", k),  {31'h0, any_i}, {31'h0, tbl[k].e_any});
      chk($sformatf("vec%0d_fp_data", k),  rd_data_f[31:0], tbl[k].e_fp);
      idle();
    end

    // Reset, then sweep every register on all ports.
    clear = 1'b1;
    cycle();
    idle();
    for (int a = 0; a < 32; a += 3) begin
      rd_en = 3'b111;
      for (int i = 0; i < 3; i++) ra[i] = 5'((a + i) % 32);
      cycle();
      for (int i = 0; i < 3; i++)
        chk($sformatf("sweep_x%0d", (a + i) % 32), rd_data_i[i*32 +: 32], 32'h0);
      chk("sweep_any", {31'h0, any_i}, 32'h0);
    end
    idle();

    // Disabled read port holds its previous result across a write.
    wr_en = 2'b01; wa[0] = 5'd12; wd[0] = 32'hA5A5A5A5; rd_en = 3'b001; ra[0] = 5'd12;
    cycle();
    chk("hold_first", rd_data_i[31:0], 32'hA5A5A5A5);
    wr_en = 2'b01; wa[0] = 5'd12; wd[0] = 32'h5A5A5A5A; rd_en = 3'b000;
    cycle();
    chk("hold_kept", rd_data_i[31:0], 32'hA5A5A5A5);
    wr_en = 2'b00; rd_en = 3'b001;
    cycle();
    chk("hold_new", rd_data_i[31:0], 32'h5A5A5A5A);
    idle();

    // any_busy drops the cycle after the last pending bit clears.
    rsv_en = 1'b1; rsv_addr = 5'd20;
    cycle();
    rsv_en = 1'b1; rsv_addr = 5'd21;
    cycle();
    chk("any_two", {31'h0, any_i}, 32'h1);
    rsv_en = 1'b0; wr_en = 2'b01; wa[0] = 5'd20; wd[0] = 32'h1;
    cycle();
    chk("any_one_left", {31'h0, any_i}, 32'h1);
    wr_en = 2'b10; wa[1] = 5'd21; wd[1] = 32'h2;
    cycle();
    chk("any_drained", {31'h0, any_i}, 32'h0);
    idle();

    // Random traffic against the model; small address window half the time
    // to provoke collisions and read/write/reserve overlaps.
    for (int n = 0; n < 400; n++) begin
      clear    = ($urandom_range(0, 39) == 0);
      rd_en    = 3'($urandom_range(0, 7));
      wr_en    = 2'($urandom_range(0, 3));
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      for (int i = 0; i < 3; i++)
        ra[i] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      for (int j = 0; j < 2; j++) begin
        wa[j] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wd[j] = $urandom;
      end
      cycle();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
